sigmoid_stream: RTL and testbench

SIGMOID_STREAM -- requirements
Module: sigmoid_stream

---
 rtl/sigmoid_stream.sv | 151 +++++++++++++++
 tb/tb_sigmoid_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_stream.sv
// Piecewise-linear sigmoid over an NCH-channel score vector, one channel per cycle; SIGMOID_ROUND_EN selects round-to-nearest.
// Latency: channel i of a vector accepted on edge E appears on out_* after edge E+2+i.
// Backpressure: out_ready low freezes issue and both stages; in_ready is high only while idle.
module sigmoid_stream #(
    parameter int W     = 8,
    parameter int FRAC  = 6,
    parameter int SHIFT = 8,
    parameter int NSEG  = 4,
    parameter int NCH   = 4,
    parameter int ZW    = W + 5,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*ZW-1:0] in_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_p,
    output logic [CHW-1:0]    out_ch,
    output logic              out_last
);
    localparam int HW = FRAC + 6;
    localparam logic [HW-1:0] ONE_V  = HW'(2 ** (FRAC + 4));
    localparam logic [HW-1:0] HALF_V = HW'(2 ** (FRAC + 3));
    localparam logic [HW-1:0] PMAX   = HW'(2 ** FRAC);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state, state_nxt;
    logic [CHW-1:0]        idx;
    logic signed [ZW-1:0]  vec [NCH];
    logic                  advance, accept, last_issue, issue_now;

    assign advance    = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_issue = (idx == CHW'(NCH - 1));
    assign issue_now  = (state == ISSUE) && advance;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (advance && last_issue)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                idx <= '0;
            else if (issue_now)
                idx <= last_issue ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < NCH; c++)
                vec[c] <= in_z[c*ZW +: ZW];
        end
    end

    // S1: segment decode; slope is the segment's rise over one 2^SHIFT step
    logic signed [ZW-1:0]    z;
    logic [SHIFT-1:0]        f;
    int                      kk;
    logic [HW-1:0]           slope, base, h_calc;
    logic [HW+SHIFT-1:0]     prod;

    always_comb begin
        z      = vec[idx];
        kk     = int'(z >>> SHIFT);
        f      = z[SHIFT-1:0];
        slope  = '0;
        base   = '0;
        prod   = '0;
        h_calc = '0;
        if (kk >= NSEG) begin
            h_calc = ONE_V;
        end else if (kk >= -NSEG) begin
            if (kk >= 0) begin
                slope = HALF_V >> (kk + 1);
                base  = ONE_V - (HALF_V >> kk);
            end else begin
                slope = HALF_V >> (-kk);
                base  = slope;
            end
            prod   = (HW+SHIFT)'(slope) * (HW+SHIFT)'(f);
            h_calc = base + HW'(prod >> SHIFT);
        end
    end

    logic                  s1_vld, s1_last;
    logic [HW-1:0]         s1_h;
    logic [CHW-1:0]        s1_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_h    <= '0;
            s1_ch   <= '0;
            s1_last <= 1'b0;
        end else if (advance) begin
            s1_vld  <= (state == ISSUE);
            s1_h    <= h_calc;
            s1_ch   <= idx;
            s1_last <= last_issue;
        end
    end

    // S2: drop the 4 guard bits, then clip to 1.0
    logic [HW-1:0] r, rc;

    always_comb begin
`ifdef SIGMOID_ROUND_EN
        r = (s1_h + HW'(8)) >> 4;
`else
        r = s1_h >> 4;
`endif
        rc = (r > PMAX) ? PMAX : r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_vld;
            out_p     <= W'(rc);
            out_ch    <= s1_ch;
            out_last  <= s1_last;
        end
    end
endmodule

// File: tb/tb_sigmoid_stream.sv
// Bench for sigmoid_stream: directed vectors, literal latency checks and a model-driven scoreboard.
module tb_sigmoid_stream;
    localparam int W = 8, FRAC = 6, SHIFT = 8, NSEG = 4, NCH = 4, ZW = 13, CHW = 2;

    logic              clk = 1'b0;
    logic              rst, in_valid, out_ready;
    logic [NCH*ZW-1:0] in_z;
    logic              in_ready, out_valid, out_last;
    logic [W-1:0]      out_p;
    logic [CHW-1:0]    out_ch;

    sigmoid_stream #(.W(W), .FRAC(FRAC), .SHIFT(SHIFT), .NSEG(NSEG), .NCH(NCH), .ZW(ZW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ch(out_ch),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, out_cnt = 0, last_cnt = 0;

    typedef struct { int p; int ch; int last; } exp_t;
    exp_t q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference sigmoid from floor division of the score into 2^SHIFT-wide segments.
    function automatic int model(input int z);
        int seg, one, half, k, f, h, r;
        seg  = 1 << SHIFT;
        one  = 1 << (FRAC + 4);
        half = one / 2;
        k = (z >= 0) ? z / seg : -((-z + seg - 1) / seg);
        f = z - k * seg;
        if (k >= NSEG)       h = one;
        else if (k < -NSEG)  h = 0;
        else if (k >= 0)     h = one - (half >> k) + (((half >> (k + 1)) * f) >> SHIFT);
        else                 h = (half >> (-k)) + (((half >> (-k)) * f) >> SHIFT);
`ifdef SIGMOID_ROUND_EN
        r = (h + 8) >> 4;
`else
        r = h >> 4;
`endif
        if (r > (1 << FRAC)) r = 1 << FRAC;
        return r;
    endfunction

    function automatic logic [NCH*ZW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NCH*ZW-1:0] v;
        v[0*ZW +: ZW] = ZW'(a);
        v[1*ZW +: ZW] = ZW'(b);
        v[2*ZW +: ZW] = ZW'(c);
        v[3*ZW +: ZW] = ZW'(d);
        return v;
    endfunction

    // Scoreboard: push on accepted vectors, pop on output handshakes, verify holds under stall.
    logic           hold_prev = 1'b0;
    logic [W-1:0]   p_prev;
    logic [CHW-1:0] ch_prev;
    logic           last_prev;

    always @(negedge clk) begin
        if (hold_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_p", int'(out_p), int'(p_prev));
            check("hold_ch", int'(out_ch), int'(ch_prev));
            check("hold_last", int'(out_last), int'(last_prev));
        end
        hold_prev = out_valid && !out_ready && !rst;
        p_prev    = out_p;
        ch_prev   = out_ch;
        last_prev = out_last;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                if (out_last) last_cnt++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: output p=%0d ch=%0d with nothing expected", out_p, out_ch);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_p", int'(out_p), e.p);
                    check("sb_ch", int'(out_ch), e.ch);
                    check("sb_last", int'(out_last), e.last);
                end
            end
            if (in_valid && in_ready) begin
                for (int c = 0; c < NCH; c++) begin
                    logic signed [ZW-1:0] zz;
                    exp_t e;
                    zz     = in_z[c*ZW +: ZW];
                    e.p    = model(int'(zz));
                    e.ch   = c;
                    e.last = (c == NCH - 1) ? 1 : 0;
                    q.push_back(e);
                end
            end
        end
    end

    // Accept at edge E, then check exact latency and issue-done timing.
    task automatic run_vec(input logic [NCH*ZW-1:0] v, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check("pre_in_ready", int'(in_ready), 1);
        in_z = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("e0_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("e1_out_valid", int'(out_valid), 0);
        for (int i = 0; i < NCH; i++) begin
            @(posedge clk); #1;
            check("lat_valid", int'(out_valid), 1);
            check("lat_p", int'(out_p), e[i]);
            check("lat_ch", int'(out_ch), i);
            check("lat_last", int'(out_last), (i == NCH - 1) ? 1 : 0);
            if (i == 0) check("issue_busy", int'(in_ready), 0);
            if (i == 2) check("issue_done", int'(in_ready), 1);
        end
        @(posedge clk); #1;
        check("drained_valid", int'(out_valid), 0);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(posedge clk); #1;
            done = (q.size() == 0) && !out_valid && in_ready;
        end
        check("drain_done", int'(done), 1);
    endtask

    initial begin
        int c0, l0;
        bit acc;
        logic [NCH*ZW-1:0] vecs [2];
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_z = '0;

        check("model_0", model(0), 32);
        check("model_1024", model(1024), 64);
        check("model_m1024", model(-1024), 2);
        check("model_m1281", model(-1281), 0);
`ifdef SIGMOID_ROUND_EN
        check("model_255", model(255), 48);
        check("model_m1", model(-1), 32);
`else
        check("model_255", model(255), 47);
        check("model_m1", model(-1), 31);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_p", int'(out_p), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_last", int'(out_last), 0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef SIGMOID_ROUND_EN
        run_vec(pack4(0, 255, -1, 1024), 32, 48, 32, 64);
`else
        run_vec(pack4(0, 255, -1, 1024), 32, 47, 31, 64);
`endif
        run_vec(pack4(-1024, -1281, 4095, -4096), 2, 0, 64, 0);

        // Stall for three cycles with channel 1 presented.
        c0 = out_cnt;
        in_z = pack4(100, -300, 700, -700);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_ch_before", int'(out_ch), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_ch", int'(out_ch), 1);
            check("bp_p", int'(out_p), model(-300));
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        wait_drain();
        check("bp_count", out_cnt - c0, 4);

        // Reset one cycle after acceptance aborts the vector.
        c0 = out_cnt;
        in_z = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_out", out_cnt - c0, 0);

        // Reset wins over a same-edge in_valid.
        in_z = pack4(5, 6, 7, 8);
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rstwin_in_ready", int'(in_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        check("rstwin_no_out", out_cnt - c0, 0);

        // Two vectors with in_valid held.
        c0 = out_cnt;
        l0 = last_cnt;
        vecs[0] = pack4(-1, -256, -257, -768);
        vecs[1] = pack4(511, 512, 767, 1023);
        in_valid = 1'b1;
        for (int v = 0; v < 2; v++) begin
            in_z = vecs[v];
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            check("b2b_accept", int'(acc), 1);
        end
        in_valid = 1'b0;
        wait_drain();
        check("b2b_count", out_cnt - c0, 8);
        check("b2b_last", last_cnt - l0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
